// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - streams a run of BRAM words out through a 2-entry FIFO
// Reads length words starting at start_addr (wrapping) and presents them as a valid/ready stream.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic [ADDR_WIDTH:0]   out_cnt_q, out_cnt_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] fifo0_q, fifo0_d, fifo1_q, fifo1_d;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic       pop, issue, last_beat;
  logic [2:0] occ_sum;

  assign m_valid   = (count_q != 2'd0);
  assign m_data    = rd_ptr_q ? fifo1_q : fifo0_q;
  assign last_beat = (out_cnt_q == (len_q - CNT_ONE));
  assign m_last    = m_valid && last_beat;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = 1'b0;
  assign busy      = busy_q;
  assign done      = done_q;

  // The address on ram_addr is "issued" in the cycle it is accepted; if not accepted
  // it simply stays on the bus and is re-read, so only one read is ever in flight.
  always_comb begin
    pop     = m_valid && m_ready;
    occ_sum = {1'b0, count_q} + {2'b00, pend_q};
    issue   = (state_q == RUN) && (issued_q < len_q) &&
              (occ_sum < (3'd2 + {2'b00, pop}));

    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    out_cnt_d  = out_cnt_q;
    ram_addr_d = ram_addr_q;
    pend_d     = issue;
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + 2'(pend_q) - 2'(pop);
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (issue) begin
      ram_addr_d = ram_addr_q + ADDR_ONE;
      issued_d   = issued_q + CNT_ONE;
    end
    if (pend_q) begin
      if (wr_ptr_q) fifo1_d = ram_q;
      else          fifo0_d = ram_q;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      out_cnt_d = out_cnt_q + CNT_ONE;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d    = RUN;
            len_d      = length;
            ram_addr_d = start_addr;
            issued_d   = '0;
            out_cnt_d  = '0;
            busy_d     = 1'b1;
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (pop && last_beat) begin
          state_d = FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      out_cnt_q  <= '0;
      ram_addr_q <= '0;
      pend_q     <= 1'b0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      out_cnt_q  <= out_cnt_d;
      ram_addr_q <= ram_addr_d;
      pend_q     <= pend_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - directed self-checking bench for bram_stream_reader
module tb_bram_stream_reader;
  logic       clk = 1'b0;
  logic       rst, start, m_ready;
  logic [5:0] start_addr, ram_addr;
  logic [6:0] length;
  logic       ram_we;
  logic [7:0] ram_q, m_data;
  logic       m_valid, m_last, busy, done;

  logic [7:0] mem [0:63];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] beats[$];
  bit         lasts[$];
  int first_cyc, last_cyc, done_cyc, done_cnt, valid_seen;
  int stable_err, fifo_err, busy_c1, busy_done, valid_after;

  bram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    logic [5:0] pat;
    pat = 6'b101001;
    if (mode == 0) return 1'b1;
    return pat[c % 6];
  endfunction

  // Issues one command at cycle 0 and records every handshake until two cycles past done.
  task automatic run_cmd(input logic [5:0] sa, input logic [6:0] len, input int mode,
                         input int pulse_c, input int max_cyc);
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    beats.delete(); lasts.delete();
    first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0; valid_seen = 0;
    stable_err = 0; fifo_err = 0; busy_c1 = 0; busy_done = 1; valid_after = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    @(negedge clk);
    start = 1'b1; start_addr = sa; length = len; m_ready = rdy(mode, 0);
    for (int c = 1; c < max_cyc; c++) begin
      @(negedge clk);
      start = (c == pulse_c);
      if (c == pulse_c) begin
        start_addr = 6'd40;
        length     = 7'd3;
      end
      m_ready = rdy(mode, c);
      if (c == 1) busy_c1 = busy;
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stable_err++;
      if (m_valid) valid_seen++;
      if (done_cnt > 0 && m_valid) valid_after++;
      if (m_valid && m_ready) begin
        beats.push_back(m_data);
        lasts.push_back(m_last);
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
      end
      if (done) begin
        done_cnt++;
        done_cyc  = c;
        busy_done = busy;
      end
      if (dut.count_q > 2'd2) fifo_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done_cnt > 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic check_beats(input string tag, input int base, input int n);
    check({tag, "_count"}, beats.size(), n);
    for (int i = 0; i < n && i < beats.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), beats[i], (base + i) % 64);
      check($sformatf("%s_last%0d", tag, i), lasts[i], (i == n - 1));
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_fifo"}, fifo_err, 0);
  endtask

  initial begin
    int dn, vs;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_m_data", m_data, 0);
    check("rst_ram_we", ram_we, 0);
    rst = 1'b0;

    run_cmd(6'd5, 7'd4, 0, 4, 40);
    check_beats("basic", 5, 4);
    check("basic_first_cyc", first_cyc, 3);
    check("basic_last_cyc", last_cyc, 6);
    check("basic_done_cyc", done_cyc, 7);
    check("basic_busy_c1", busy_c1, 1);
    check("basic_busy_at_done", busy_done, 0);
    check("basic_valid_after_done", valid_after, 0);

    run_cmd(6'd62, 7'd4, 0, -1, 40);
    check_beats("wrap", 62, 4);

    run_cmd(6'd0, 7'd64, 0, -1, 120);
    check_beats("full", 0, 64);
    check("full_last_cyc", last_cyc, 66);

    run_cmd(6'd20, 7'd4, 1, -1, 60);
    check_beats("stall", 20, 4);
    check("stall_stable", stable_err, 0);

    run_cmd(6'd7, 7'd0, 0, -1, 20);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_valid_seen", valid_seen, 0);

    @(negedge clk);
    start = 1'b1; start_addr = 6'd0; length = 7'd8; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_second_beat", m_data, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_m_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    dn = 0; vs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dn++;
      if (m_valid) vs++;
    end
    check("abort_no_done", dn, 0);
    check("abort_no_valid", vs, 0);

    run_cmd(6'd10, 7'd2, 0, -1, 40);
    check_beats("after_abort", 10, 2);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
